// File: rtl/stream_serializer_async.sv
// Width down-converter: one OUT_WIDTH*RATIO-bit word in, RATIO OUT_WIDTH-bit beats out, last beat flagged.
// Latency: a word accepted at edge N presents beat 0 right after edge N; words stream back to back with no bubbles.
// Backpressure: a one-word holding register absorbs stalls; in_ready is registered-only (no out_ready->in_ready path).
// Build option: define STREAM_SERIALIZER_MSB_FIRST_EN to emit the most-significant slice first (default is LSB first).
module stream_serializer_async #(
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = 4   // must be >= 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [OUT_WIDTH*RATIO-1:0]     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last
);

  localparam int BEAT_W = $clog2(RATIO);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  // 2'b00 is deliberately unused so a corrupted register is decodable as illegal.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b01,  // nothing held
    ST_BUSY  = 2'b10,  // cur held, pend empty
    ST_FULL  = 2'b11   // cur and pend both held
  } state_t;

  // A word viewed as RATIO slices, slice 0 being the least-significant bits.
  typedef logic [RATIO-1:0][OUT_WIDTH-1:0] word_t;

  state_t            state;
  state_t            state_nxt;
  word_t             cur;
  word_t             pend;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_sel;
  logic              past_reset;

  logic rx;
  logic tx;
  logic last_tx;
  logic load_cur_in;
  logic load_cur_pend;
  logic load_pend;

  // Handshake events and the datapath actions they trigger in each state.
  assign rx            = in_valid && in_ready;
  assign tx            = out_valid && out_ready;
  assign last_tx       = tx && (beat == LAST_BEAT);
  assign load_cur_in   = rx && ((state == ST_EMPTY) || ((state == ST_BUSY) && last_tx));
  assign load_cur_pend = (state == ST_FULL) && last_tx;
  assign load_pend     = rx && (state == ST_BUSY) && !last_tx;

  // Holds in_ready low from reset assertion until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      past_reset <= 1'b1;
    end else begin
      past_reset <= 1'b0;
    end
  end

  // State register; asynchronous reset drops out_valid immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode from the input/output handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (rx) begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rx && !last_tx) begin
          state_nxt = ST_FULL;
        end else if (!rx && last_tx) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // rx cannot happen here because in_ready is low.
        if (last_tx) begin
          state_nxt = ST_BUSY;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Beat index: cleared only by a word load, advanced by non-final beats, never wraps on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat <= '0;
    end else if (load_cur_in || load_cur_pend) begin
      beat <= '0;
    end else if (tx && !last_tx) begin
      beat <= beat + BEAT_W'(1);
    end
  end

  // Word storage is not reset; its content is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (load_cur_in) begin
      cur <= in_data;
    end else if (load_cur_pend) begin
      cur <= pend;
    end
    if (load_pend) begin
      pend <= in_data;
    end
  end

  // Map the beat index to the slice to emit; order is a build-time choice.
  always_comb begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    beat_sel = LAST_BEAT - beat;
`else
    beat_sel = beat;
`endif
  end

  // Output decode; in_ready depends only on registers.
  always_comb begin
    out_valid = (state != ST_EMPTY);
    out_last  = (state != ST_EMPTY) && (beat == LAST_BEAT);
    in_ready  = (state != ST_FULL) && !past_reset;
    out_data  = cur[beat_sel];
  end

endmodule

// File: tb/tb_stream_serializer_async.sv
// Directed bench for stream_serializer_async with OUT_WIDTH=8, RATIO=4.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point, away from the edge.
// Expected beat order follows STREAM_SERIALIZER_MSB_FIRST_EN when the bench is built with it.
module tb_stream_serializer_async;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int errors;
  int checks;

  stream_serializer_async #(
    .OUT_WIDTH (8),
    .RATIO     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_beat(input logic [31:0] w, input int k);
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    return w[(3 - k) * 8 +: 8];
`else
    return w[k * 8 +: 8];
`endif
  endfunction

  task automatic expect_beat(input string tag, input logic [31:0] w, input int k);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data),  32'(exp_beat(w, k)));
    check({tag, ".last"},  32'(out_last),  32'(k == 3));
  endtask

  logic [31:0] w1, w2, w3, w4;
  logic [8:0]  stall_pat;
  logic [7:0]  held_data;
  logic        held_last;
  int          idx;

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    w1 = 32'h44332211;
    w2 = 32'h88776655;
    w3 = 32'hCCBBAA99;
    w4 = 32'hDDCCBBAA;

    // Reset state
    tick();
    tick();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_last",  32'(out_last),  32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    reset = 1'b0;
    check("rel.in_ready_hold", 32'(in_ready), 32'd0);
    tick();
    check("rel.in_ready_up", 32'(in_ready), 32'd1);
    check("rel.out_valid",   32'(out_valid), 32'd0);

    // Single word
    out_ready = 1'b1;
    in_data   = w1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_beat($sformatf("single.b%0d", k), w1, k);
      tick();
    end
    check("single.idle", 32'(out_valid), 32'd0);

    // Back-to-back words, no bubble
    in_data  = w1;
    in_valid = 1'b1;
    tick();
    in_data = w2;
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    expect_beat("b2b.w1b0", w1, 0);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      expect_beat($sformatf("b2b.w1b%0d", k), w1, k);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      expect_beat($sformatf("b2b.w2b%0d", k), w2, k);
      tick();
    end
    check("b2b.idle", 32'(out_valid), 32'd0);

    // Backpressure: two words absorbed, third refused until the first word drains
    out_ready = 1'b0;
    in_data   = w1;
    in_valid  = 1'b1;
    tick();
    in_data = w2;
    tick();
    in_data = w3;
    check("bp.full_in_ready", 32'(in_ready), 32'd0);
    expect_beat("bp.stall0", w1, 0);
    tick();
    check("bp.full_in_ready2", 32'(in_ready), 32'd0);
    expect_beat("bp.stall1", w1, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp.w1_in_ready%0d", k), 32'(in_ready), 32'd0);
      expect_beat($sformatf("bp.w1b%0d", k), w1, k);
      tick();
    end
    check("bp.third_in_ready", 32'(in_ready), 32'd1);
    expect_beat("bp.w2b0", w2, 0);
    tick();
    in_valid = 1'b0;
    check("bp.third_taken", 32'(in_ready), 32'd0);
    for (int k = 1; k < 4; k++) begin
      expect_beat($sformatf("bp.w2b%0d", k), w2, k);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      expect_beat($sformatf("bp.w3b%0d", k), w3, k);
      tick();
    end
    check("bp.idle", 32'(out_valid), 32'd0);

    // Stall stability: outputs frozen on every cycle with out_ready low
    stall_pat = 9'b100101001;  // consumed LSB first: 1,0,0,1,0,1,0,0,1
    in_data   = w4;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    idx = 0;
    for (int i = 0; i < 9; i++) begin
      out_ready = stall_pat[i];
      expect_beat($sformatf("stall.c%0d", i), w4, idx);
      held_data = out_data;
      held_last = out_last;
      tick();
      if (stall_pat[i]) begin
        idx++;
      end else begin
        check($sformatf("stall.hold_data%0d", i), 32'(out_data), 32'(held_data));
        check($sformatf("stall.hold_last%0d", i), 32'(out_last), 32'(held_last));
      end
    end
    check("stall.beats_done", 32'(idx), 32'd4);
    check("stall.idle", 32'(out_valid), 32'd0);

    // Reset mid-word
    out_ready = 1'b1;
    in_data   = w1;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_beat("mid.b0", w1, 0);
    tick();
    expect_beat("mid.b1", w1, 1);
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("mid.async_valid", 32'(out_valid), 32'd0);
    check("mid.async_last",  32'(out_last),  32'd0);
    check("mid.async_ready", 32'(in_ready),  32'd0);
    tick();
    reset = 1'b0;
    check("mid.rel_ready_hold", 32'(in_ready), 32'd0);
    tick();
    check("mid.rel_ready_up", 32'(in_ready),  32'd1);
    check("mid.discarded",    32'(out_valid), 32'd0);
    in_data  = w4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_beat($sformatf("mid.w4b%0d", k), w4, k);
      tick();
    end
    check("mid.idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_serializer_async.md
# stream_serializer_async

Valid/ready width down-converter: accepts one wide word of `OUT_WIDTH*RATIO` bits and transmits it as `RATIO` consecutive narrow beats, flagging the final beat with `out_last`. It is the transmit-side counterpart of our buffered stream receivers and sits between a wide internal datapath and a narrow AXI-Stream-style link. Internal buffering sustains one beat per cycle with no bubbles between words, and `in_ready` is registered, so there is no combinational `out_ready`→`in_ready` path.

## Interface
Parameters:
- `OUT_WIDTH`, default 8: width of one output beat in bits.
- `RATIO`, default 4: beats per input word. Must be ≥ 2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high; clock `clk`.
- `in_data`, in, `OUT_WIDTH*RATIO`: wide input word.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block accepts a word this cycle.
- `out_data`, out, `OUT_WIDTH`: current beat.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_last`, out, 1: current beat is the final beat of its word.

## Operation
- Input handshake (`rx`) = `in_valid && in_ready`. Output handshake (`tx`) = `out_valid && out_ready`. `last_tx` = `tx` on beat index `RATIO-1`.
- Storage:
  - `cur`: word being sent.
  - `pend`: one-word holding register.
  - `beat`: index counter, `$clog2(RATIO)` bits.
- FSM has three states, one-hot-free 2-bit encoding; code `2'b00` is illegal.
  - EMPTY: nothing held.
  - BUSY: `cur` held, `pend` empty.
  - FULL: both held.
- EMPTY:
  - `rx` → load `cur` from `in_data`, set `beat`=0, go to BUSY.
- BUSY:
  - `rx` and `last_tx` → load `cur` from `in_data`, set `beat`=0, stay in BUSY.
  - `rx` without `last_tx` → load `pend`, go to FULL. If `tx` also occurs, `beat` increments.
  - `last_tx` without `rx` → go to EMPTY.
  - `tx` that is not the last beat → `beat`+1.
- FULL (`rx` is impossible here):
  - `last_tx` → `cur` takes `pend`, `beat`=0, go to BUSY.
  - Other `tx` → `beat`+1.
- With no `rx` and no `tx`, state, `beat`, `cur` and `pend` all hold.
- Outputs:
  - `out_valid` = (state ≠ EMPTY).
  - `in_ready` = (state ≠ FULL) && !`past_reset`. `past_reset` is a flop set asynchronously by `reset` and cleared on the first `clk` edge after `reset` falls.
  - `out_last` = `out_valid` && (`beat` == `RATIO-1`).
  - `out_data` = `cur[beat*OUT_WIDTH +: OUT_WIDTH]` by default. See Configuration.
- Arithmetic: `beat` never exceeds `RATIO-1`. It returns to 0 only through a word load, never by free-running wrap.
- Words are emitted strictly in acceptance order; none is dropped or duplicated.

## Timing
- Reset values while `reset` is asserted:
  - state = EMPTY, `beat`=0.
  - `out_valid`=0, `out_last`=0, `in_ready`=0.
  - `out_data` is not reset and is don't-care while `out_valid`=0.
  - `cur` and `pend` are not reset.
- `in_ready` stays 0 for one full cycle after `reset` deasserts.
- Reset asserted mid-word drops `out_valid` immediately (asynchronously) and discards `cur` and `pend`.
- Latency: a word accepted at edge N presents beat 0 with `out_valid`=1 after edge N.
- Throughput: with `out_ready` held at 1 and input always valid, one beat per cycle indefinitely. The next word's beat 0 directly follows the previous `out_last`.
- `out_data`, `out_valid` and `out_last` hold stable while `out_valid && !out_ready`.
- `in_ready` depends only on registers.

## Configuration
- Macro `STREAM_SERIALIZER_MSB_FIRST_EN`.
- Defined: beat k = `cur[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH]`, i.e. most-significant slice first.
- Undefined (default): beat k = `cur[k*OUT_WIDTH +: OUT_WIDTH]`, i.e. least-significant slice first.
- Handshake, FSM and timing are identical in both builds.

## Test plan
All scenarios use `OUT_WIDTH`=8, `RATIO`=4.
- Single word: reset, then push `0x44332211` with `out_ready`=1 → beats `11,22,33,44` on 4 consecutive cycles, `out_last` only on `44`, then `out_valid`=0.
- Back-to-back: push `0x44332211` then `0x88776655` continuously, `out_ready`=1 → 8 beats `11..88` on 8 consecutive cycles, no bubble, `out_last` on `44` and `88`.
- Backpressure: hold `out_ready`=0 and offer 3 words → first two accepted, `in_ready`=0 (FULL). Then release → third word accepted on the cycle after `44` transfers, and all 12 beats arrive in order.
- Stall stability: toggle `out_ready` 1,0,0,1,… during a word → `out_data` and `out_last` stay unchanged on every stalled cycle, and the beat sequence is correct.
- Reset mid-word: assert `reset` after beat `22` → `out_valid`=0 immediately. After release, `in_ready`=0 for 1 cycle. Then `0xDDCCBBAA` → `AA,BB,CC,DD`.
- With `STREAM_SERIALIZER_MSB_FIRST_EN`: push `0x44332211` → `44,33,22,11`, `out_last` on `11`.
